// File: rtl/writeback_arbiter_pkg.sv
// wb_pkg: shared widths and the queued write-request record for the writeback arbiter
package wb_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: producer handshakes and register-file write port of the writeback arbiter
interface writeback_arbiter_if;
  import wb_pkg::*;
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_valid;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              wb_en;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, wb_en, wb_rd, wb_data
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/writeback_arbiter_fifo.sv
// wb_fifo: in-order circular buffer of pending ALU writes, exposing every entry for forwarding
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output wb_req_t               head,
  output wb_req_t [DEPTH-1:0]   entries,
  output logic    [DEPTH-1:0]   valid,
  output logic    [AW-1:0]      head_ptr,
  output logic    [CW-1:0]      count
);
  logic    [AW-1:0]    tail_ptr;
  wb_req_t [DEPTH-1:0] mem;
  // pointers, occupancy and per-entry valid bits; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      valid    <= '0;
    end else begin
      if (push) begin
        tail_ptr        <= tail_ptr + 1'b1;
        valid[tail_ptr] <= 1'b1;
      end
      if (pop) begin
        head_ptr        <= head_ptr + 1'b1;
        valid[head_ptr] <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // payload storage needs no reset: the valid bits decide what is visible
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_req;
  end
  assign head    = mem[head_ptr];
  assign entries = mem;
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges load and queued ALU results onto the register-file write port with forwarding
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  writeback_arbiter_if.slave       bus,
  input  logic [REG_AW-1:0]        q_rs1,
  input  logic [REG_AW-1:0]        q_rs2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [XLEN-1:0]          q_data1,
  output logic [XLEN-1:0]          q_data2,
  output logic [CW-1:0]            fifo_count
);
  wb_req_t               head;
  wb_req_t [DEPTH-1:0]   entries;
  logic    [DEPTH-1:0]   valid;
  logic    [AW-1:0]      head_ptr;
  logic                  empty;
  logic                  alu_fire;
  logic                  push;
  logic                  pop;
  assign empty         = fifo_count == '0;
  assign bus.alu_ready = fifo_count != CW'(DEPTH);
  assign alu_fire      = bus.alu_valid && bus.alu_ready;
  assign pop           = !bus.ld_valid && !empty;
  // enqueue only when the ALU result cannot go straight out; x0 results are dropped
  assign push          = alu_fire && bus.alu_rd != '0 && (bus.ld_valid || !empty);
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_req ('{rd: bus.alu_rd, data: bus.alu_data}),
    .pop      (pop),
    .head     (head),
    .entries  (entries),
    .valid    (valid),
    .head_ptr (head_ptr),
    .count    (fifo_count)
  );
  // write-port register: load first, then FIFO head, then ALU bypass, else idle holding rd/data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_en   <= 1'b0;
      bus.wb_rd   <= '0;
      bus.wb_data <= '0;
    end else if (bus.ld_valid) begin
      bus.wb_en   <= bus.ld_rd != '0;
      bus.wb_rd   <= bus.ld_rd;
      bus.wb_data <= bus.ld_data;
    end else if (!empty) begin
      bus.wb_en   <= 1'b1;
      bus.wb_rd   <= head.rd;
      bus.wb_data <= head.data;
    end else if (bus.alu_valid) begin
      bus.wb_en   <= bus.alu_rd != '0;
      bus.wb_rd   <= bus.alu_rd;
      bus.wb_data <= bus.alu_data;
    end else begin
      bus.wb_en   <= 1'b0;
    end
  end
  // oldest source first (in-flight write, then FIFO head to tail) so the youngest match overwrites
  function automatic logic [XLEN:0] lookup(input logic [REG_AW-1:0] q);
    logic [XLEN:0] r;
    logic [AW-1:0] idx;
    r = '0;
    if (q != '0) begin
      if (bus.wb_en && bus.wb_rd == q) r = {1'b1, bus.wb_data};
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_ptr + AW'(k);
        if (valid[idx] && entries[idx].rd == q) r = {1'b1, entries[idx].data};
      end
    end
    return r;
  endfunction
  // forwarding answers for both decode read ports
  always_comb begin
    {q_hit1, q_data1} = lookup(q_rs1);
    {q_hit2, q_data2} = lookup(q_rs2);
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vector table plus reset-mid-drain sequence for writeback_arbiter
module tb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  q_rs1, q_rs2;
  logic        q_hit1, q_hit2;
  logic [31:0] q_data1, q_data2;
  logic [2:0]  fifo_count;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  writeback_arbiter_if bus();

  writeback_arbiter #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .q_rs1      (q_rs1),
    .q_rs2      (q_rs2),
    .q_hit1     (q_hit1),
    .q_hit2     (q_hit2),
    .q_data1    (q_data1),
    .q_data2    (q_data2),
    .fifo_count (fifo_count)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        rdy;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        cd;
    logic [2:0]  cnt;
    logic        h1;
    logic [31:0] qd1;
    logic        h2;
    logic [31:0] qd2;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic [4:0] q1, input logic [4:0] q2);
    bus.alu_valid = av;
    bus.alu_rd    = ar;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lr;
    bus.ld_data   = ld;
    q_rs1         = q1;
    q_rs2         = q2;
  endtask

  task automatic add(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                     input logic [4:0] q1, input logic [4:0] q2, input logic rdy,
                     input logic en, input logic [4:0] rd, input logic [31:0] d, input logic cd,
                     input logic [2:0] cnt, input logic h1, input logic [31:0] qd1,
                     input logic h2, input logic [31:0] qd2);
    vec_t t;
    t = '{av, ar, ad, lv, lr, ld, q1, q2, rdy, en, rd, d, cd, cnt, h1, qd1, h2, qd2};
    vq.push_back(t);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset.wb_en", 32'(bus.wb_en), 0);
    check("reset.wb_rd", 32'(bus.wb_rd), 0);
    check("reset.wb_data", bus.wb_data, 0);
    check("reset.count", 32'(fifo_count), 0);
    check("reset.alu_ready", 32'(bus.alu_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    //  av ar  ad       lv lr  ld       q1  q2  rdy en rd  d        cd cnt h1 qd1      h2 qd2
    add(1, 5,  32'h1234, 0, 0,  0,       5,  0,  1,  1, 5,  32'h1234, 1, 0, 1, 32'h1234, 0, 0);
    add(0, 0,  0,        0, 0,  0,       5,  5,  1,  0, 5,  32'h1234, 1, 0, 0, 0,        0, 0);
    add(1, 7,  32'hBBBB, 1, 3,  32'hAAAA, 7, 3,  1,  1, 3,  32'hAAAA, 1, 1, 1, 32'hBBBB, 1, 32'hAAAA);
    add(0, 0,  0,        0, 0,  0,       7,  3,  1,  1, 7,  32'hBBBB, 1, 0, 1, 32'hBBBB, 0, 0);
    add(1, 9,  32'h11,   1, 10, 32'h10,  9,  0,  1,  1, 10, 32'h10,   1, 1, 1, 32'h11,   0, 0);
    add(1, 9,  32'h22,   1, 11, 32'h20,  9,  10, 1,  1, 11, 32'h20,   1, 2, 1, 32'h22,   0, 0);
    add(0, 0,  0,        0, 0,  0,       9,  11, 1,  1, 9,  32'h11,   1, 1, 1, 32'h22,   0, 0);
    add(1, 0,  32'h55,   0, 0,  0,       9,  0,  1,  1, 9,  32'h22,   1, 0, 1, 32'h22,   0, 0);
    add(1, 0,  32'h66,   1, 0,  32'h77,  0,  9,  1,  0, 0,  0,        0, 0, 0, 0,        0, 0);
    add(1, 0,  32'h88,   0, 0,  0,       9,  0,  1,  0, 0,  0,        0, 0, 0, 0,        0, 0);
    add(0, 0,  0,        0, 0,  0,       0,  0,  1,  0, 0,  0,        0, 0, 0, 0,        0, 0);
    add(1, 1,  32'hA1,   1, 20, 32'h100, 0,  0,  1,  1, 20, 32'h100,  1, 1, 0, 0,        0, 0);
    add(1, 2,  32'hA2,   1, 21, 32'h101, 0,  0,  1,  1, 21, 32'h101,  1, 2, 0, 0,        0, 0);
    add(1, 3,  32'hA3,   1, 22, 32'h102, 0,  0,  1,  1, 22, 32'h102,  1, 3, 0, 0,        0, 0);
    add(1, 4,  32'hA4,   1, 23, 32'h103, 4,  0,  1,  1, 23, 32'h103,  1, 4, 1, 32'hA4,   0, 0);
    add(1, 5,  32'hA5,   1, 24, 32'h104, 1,  24, 0,  1, 24, 32'h104,  1, 4, 1, 32'hA1,   1, 32'h104);
    add(1, 5,  32'hA5,   1, 25, 32'h105, 0,  0,  0,  1, 25, 32'h105,  1, 4, 0, 0,        0, 0);
    add(1, 5,  32'hA5,   0, 0,  0,       1,  0,  0,  1, 1,  32'hA1,   1, 3, 1, 32'hA1,   0, 0);
    add(1, 5,  32'hA5,   0, 0,  0,       5,  0,  1,  1, 2,  32'hA2,   1, 3, 1, 32'hA5,   0, 0);
    add(1, 6,  32'hA6,   0, 0,  0,       6,  2,  1,  1, 3,  32'hA3,   1, 3, 1, 32'hA6,   0, 0);
    add(0, 0,  0,        0, 0,  0,       0,  0,  1,  1, 4,  32'hA4,   1, 2, 0, 0,        0, 0);
    add(0, 0,  0,        0, 0,  0,       0,  0,  1,  1, 5,  32'hA5,   1, 1, 0, 0,        0, 0);
    add(0, 0,  0,        0, 0,  0,       0,  0,  1,  1, 6,  32'hA6,   1, 0, 0, 0,        0, 0);
    add(0, 0,  0,        0, 0,  0,       6,  0,  1,  0, 6,  32'hA6,   1, 0, 0, 0,        0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].av, vq[i].ar, vq[i].ad, vq[i].lv, vq[i].lr, vq[i].ld, vq[i].q1, vq[i].q2);
      #1;
      check($sformatf("v%0d.alu_ready", i), 32'(bus.alu_ready), 32'(vq[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d.wb_en", i), 32'(bus.wb_en), 32'(vq[i].en));
      if (vq[i].cd) begin
        check($sformatf("v%0d.wb_rd", i), 32'(bus.wb_rd), 32'(vq[i].rd));
        check($sformatf("v%0d.wb_data", i), bus.wb_data, vq[i].d);
      end
      check($sformatf("v%0d.count", i), 32'(fifo_count), 32'(vq[i].cnt));
      check($sformatf("v%0d.q_hit1", i), 32'(q_hit1), 32'(vq[i].h1));
      check($sformatf("v%0d.q_data1", i), q_data1, vq[i].qd1);
      check($sformatf("v%0d.q_hit2", i), 32'(q_hit2), 32'(vq[i].h2));
      check($sformatf("v%0d.q_data2", i), q_data2, vq[i].qd2);
    end

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 5'(12 + k), 32'hC0 + 32'(k), 1, 15, 32'hF0, 0, 0);
    end
    @(posedge clk);
    #1;
    check("rst_mid.pre_count", 32'(fifo_count), 3);
    check("rst_mid.pre_wb_en", 32'(bus.wb_en), 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 12, 14);
    rst_n = 1'b0;
    #1;
    check("rst_mid.wb_en", 32'(bus.wb_en), 0);
    check("rst_mid.count", 32'(fifo_count), 0);
    check("rst_mid.q_hit1", 32'(q_hit1), 0);
    check("rst_mid.q_hit2", 32'(q_hit2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d.wb_en", k), 32'(bus.wb_en), 0);
      check($sformatf("post_rst%0d.count", k), 32'(fifo_count), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
